// File: rtl/nz_lane_sequencer.sv
// rtl/nz_lane_sequencer.sv - zero-skipping lane index scheduler, MSB lane first
module nz_lane_sequencer #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 5,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_mask,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [IDX_W-1:0] o_idx,
   output logic [TAG_W-1:0] o_tag,
   output logic             o_last,
   output logic             o_zero,
   output logic [IDX_W:0]   o_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, ZERO} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   residual_q, residual_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [IDX_W:0]     cnt_q, cnt_d;

   logic [WIDTH-1:0]   lz_v;
   logic [IDX_W-1:0]   lzc;
   logic [IDX_W-1:0]   run_idx;
   logic               run_last;
   logic               beat_hs;
   logic               accept;

   // Five-level leading-zero tree: each level halves the window still in question.
   always_comb begin
      lz_v = residual_q;
      lzc  = '0;
      if (lz_v[31:16] == 16'd0) begin lzc[4] = 1'b1; lz_v = lz_v << 16; end
      if (lz_v[31:24] == 8'd0)  begin lzc[3] = 1'b1; lz_v = lz_v << 8;  end
      if (lz_v[31:28] == 4'd0)  begin lzc[2] = 1'b1; lz_v = lz_v << 4;  end
      if (lz_v[31:30] == 2'd0)  begin lzc[1] = 1'b1; lz_v = lz_v << 2;  end
      if (lz_v[31] == 1'b0)     begin lzc[0] = 1'b1; end
   end

   assign run_idx  = IDX_W'(WIDTH - 1) - lzc;
   assign run_last = (residual_q & (residual_q - WIDTH'(1))) == '0;

   always_comb begin
      o_valid = (state_q != IDLE);
      o_idx   = (state_q == RUN) ? run_idx : '0;
      o_last  = (state_q == RUN) ? run_last : (state_q == ZERO);
      o_zero  = (state_q == ZERO);
      o_cnt   = (state_q == RUN) ? cnt_q : '0;
      o_tag   = tag_q;
   end

   assign beat_hs = o_valid & i_ready;
   // Ready also opens on the final handshake so groups run back to back.
   assign o_ready = rst_n & ~i_flush & ((state_q == IDLE) | (beat_hs & o_last));
   assign accept  = i_valid & o_ready;

   always_comb begin
      state_d    = state_q;
      residual_d = residual_q;
      tag_d      = tag_q;
      cnt_d      = cnt_q;
      if (i_flush) begin
         state_d    = IDLE;
         residual_d = '0;
         cnt_d      = '0;
      end else begin
         if (beat_hs) begin
            if (state_q == RUN) begin
               residual_d = residual_q & ~(WIDTH'(1) << run_idx);
               cnt_d      = cnt_q + 1'b1;
            end
            if (o_last) state_d = IDLE;
         end
         if (accept) begin
            tag_d      = i_tag;
            cnt_d      = '0;
            residual_d = i_mask;
            state_d    = (i_mask != '0) ? RUN : ZERO;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         residual_q <= '0;
         tag_q      <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         residual_q <= residual_d;
         tag_q      <= tag_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_nz_lane_sequencer.sv
// tb/tb_nz_lane_sequencer.sv - randomized and directed bench for nz_lane_sequencer
module tb_nz_lane_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_flush = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [31:0] i_mask = '0;
   logic [7:0]  i_tag = '0;
   logic        o_valid;
   logic        i_ready = 1'b1;
   logic [4:0]  o_idx;
   logic [7:0]  o_tag;
   logic        o_last;
   logic        o_zero;
   logic [5:0]  o_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   nz_lane_sequencer #(.WIDTH(32), .IDX_W(5), .TAG_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid),
      .o_ready(o_ready), .i_mask(i_mask), .i_tag(i_tag), .o_valid(o_valid),
      .i_ready(i_ready), .o_idx(o_idx), .o_tag(o_tag), .o_last(o_last),
      .o_zero(o_zero), .o_cnt(o_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int cnt;
      bit last;
      bit zero;
   } beat_t;

   // Model: the whole group is expanded into its beat list at accept time.
   beat_t    exp_q[$];
   int       m_tag = 0;

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
   endtask

   function automatic bit m_ready();
      bit done;
      done = (exp_q.size() > 0) && exp_q[0].last && i_ready;
      return rst_n && !i_flush && ((exp_q.size() == 0) || done);
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_tag = 0;
   endtask

   task automatic model_update();
      bit acc;
      beat_t b;
      int n;
      if (!rst_n) begin
         model_reset();
         return;
      end
      acc = i_valid && m_ready();
      if (i_flush) begin
         exp_q.delete();
         return;
      end
      if (exp_q.size() > 0 && i_ready) void'(exp_q.pop_front());
      if (acc) begin
         exp_q.delete();
         m_tag = int'(i_tag);
         if (i_mask == 32'd0) begin
            b.idx = 0; b.cnt = 0; b.last = 1'b1; b.zero = 1'b1;
            exp_q.push_back(b);
         end else begin
            n = 0;
            for (int k = 31; k >= 0; k--) begin
               if (i_mask[k]) begin
                  b.idx = k; b.cnt = n; b.last = 1'b0; b.zero = 1'b0;
                  exp_q.push_back(b);
                  n++;
               end
            end
            exp_q[exp_q.size()-1].last = 1'b1;
         end
      end
   endtask

   task automatic check_model();
      beat_t b;
      chk("ready", int'(o_ready), int'(m_ready()));
      chk("valid", int'(o_valid), int'(exp_q.size() > 0));
      chk("tag", int'(o_tag), m_tag);
      if (exp_q.size() > 0) begin
         b = exp_q[0];
      end else begin
         b.idx = 0; b.cnt = 0; b.last = 1'b0; b.zero = 1'b0;
      end
      chk("idx", int'(o_idx), b.idx);
      chk("cnt", int'(o_cnt), b.cnt);
      chk("last", int'(o_last), int'(b.last));
      chk("zero", int'(o_zero), int'(b.zero));
   endtask

   task automatic settle();
      @(negedge clk);
      check_model();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic step();
      settle();
      tick();
   endtask

   task automatic offer(input logic [31:0] m, input logic [7:0] t);
      i_valid = 1'b1; i_mask = m; i_tag = t;
      step();
      i_valid = 1'b0; i_mask = $urandom; i_tag = 8'($urandom);
   endtask

   int exp1_idx[3] = '{31, 2, 0};

   initial begin
      // reset state
      #1;
      settle();
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_ready", int'(o_ready), 0);
      chk("rst_tag", int'(o_tag), 0);
      tick();
      rst_n = 1'b1;
      step();

      // three-lane group with MSB lane
      offer(32'h8000_0005, 8'h3C);
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("g1_idx", int'(o_idx), exp1_idx[k]);
         chk("g1_cnt", int'(o_cnt), k);
         chk("g1_last", int'(o_last), int'(k == 2));
         chk("g1_tag", int'(o_tag), 8'h3C);
         tick();
      end
      settle();
      chk("g1_done", int'(o_valid), 0);
      tick();

      // all-zero mask: one dummy beat
      offer(32'h0, 8'h11);
      settle();
      chk("z_zero", int'(o_zero), 1);
      chk("z_last", int'(o_last), 1);
      chk("z_idx", int'(o_idx), 0);
      tick();
      settle();
      chk("z_idle", int'(o_valid), 0);
      tick();

      // full mask, next group accepted on the final beat
      offer(32'hFFFF_FFFF, 8'h5A);
      for (int k = 0; k < 32; k++) begin
         if (k == 31) begin
            i_valid = 1'b1; i_mask = 32'h10; i_tag = 8'h77;
         end
         settle();
         chk("f_idx", int'(o_idx), 31 - k);
         chk("f_cnt", int'(o_cnt), k);
         if (k == 31) chk("f_ready_last", int'(o_ready), 1);
         tick();
      end
      i_valid = 1'b0;
      settle();
      chk("f_next_valid", int'(o_valid), 1);
      chk("f_next_idx", int'(o_idx), 4);
      chk("f_next_tag", int'(o_tag), 8'h77);
      tick();
      step();

      // backpressure on the first beat
      offer(32'h0000_0300, 8'h21);
      i_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("bp_idx", int'(o_idx), 9);
         chk("bp_valid", int'(o_valid), 1);
         tick();
      end
      i_ready = 1'b1;
      settle(); chk("bp_idx9", int'(o_idx), 9); tick();
      settle(); chk("bp_idx8", int'(o_idx), 8); chk("bp_last", int'(o_last), 1); tick();

      // flush during the second beat
      offer(32'h0000_0F00, 8'h42);
      step();
      i_flush = 1'b1;
      settle();
      chk("fl_ready", int'(o_ready), 0);
      tick();
      i_flush = 1'b0;
      settle();
      chk("fl_valid", int'(o_valid), 0);
      chk("fl_ready_after", int'(o_ready), 1);
      tick();
      offer(32'h1, 8'h43);
      settle();
      chk("fl_idx", int'(o_idx), 0);
      chk("fl_cnt", int'(o_cnt), 0);
      tick();
      step();

      // asynchronous reset mid-group
      offer(32'h0000_00F0, 8'h99);
      step();
      rst_n = 1'b0;
      #2;
      chk("ar_valid", int'(o_valid), 0);
      chk("ar_idx", int'(o_idx), 0);
      chk("ar_tag", int'(o_tag), 0);
      chk("ar_ready", int'(o_ready), 0);
      model_reset();
      tick();
      rst_n = 1'b1;
      settle();
      chk("ar_ready_rel", int'(o_ready), 1);
      chk("ar_no_stale", int'(o_valid), 0);
      tick();

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         i_valid = ($urandom_range(0, 1) == 1);
         case ($urandom_range(0, 4))
            0: i_mask = 32'h0;
            1: i_mask = 32'h1 << $urandom_range(0, 31);
            2: i_mask = 32'hFFFF_FFFF;
            default: i_mask = $urandom & $urandom;
         endcase
         i_tag   = 8'($urandom);
         i_ready = ($urandom_range(0, 3) != 0);
         i_flush = ($urandom_range(0, 39) == 0);
         step();
      end
      i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
      for (int c = 0; c < 40; c++) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
